// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Parametrised single-clock FIFO placed between the DTP
//                producer and the output mux. Read mode is selectable:
//                registered read (data one cycle after pop) or
//                first-word-fall-through. Provides an occupancy count,
//                almost-full/almost-empty thresholds and sticky
//                overflow/underflow error flags.
//  Ports       : clk, rst_n (synchronous, active-low)
//                i_push, i_data  - write request and data
//                i_pop           - read request
//                o_data, o_valid - read data and its qualifier
//                o_full, o_empty, o_afull, o_aempty, o_count - status
//                o_overflow, o_underflow - sticky error flags
//                i_clr_err       - clears both sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int  DATA_W    = 16,
    parameter int  DEPTH     = 8,
    parameter int  FWFT      = 0,
    parameter int  AFULL_TH  = 6,
    parameter int  AEMPTY_TH = 2,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_afull,
    output logic              o_aempty,
    output logic [AW:0]       o_count,
    output logic              o_overflow,
    output logic              o_underflow,
    input  logic              i_clr_err
);

    localparam logic [AW:0] c_depth     = DEPTH[AW:0];
    localparam logic [AW:0] c_afull_th  = AFULL_TH[AW:0];
    localparam logic [AW:0] c_aempty_th = AEMPTY_TH[AW:0];
    localparam logic [AW:0] c_ptr_one   = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_overflow;
    logic          r_underflow;

    logic [AW:0]   w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_pop_ok;
    logic          w_push_ok;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    // ------------------------------------------------------------------
    // Status decode straight from the registered pointers
    // ------------------------------------------------------------------
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_count == c_depth);
    assign w_empty  = (w_count == '0);
    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle; a pop from an empty FIFO is never accepted, even alongside
    // a push, because the incoming word is not yet stored.
    assign w_pop_ok  = i_pop & ~w_empty;
    assign w_push_ok = i_push & (~w_full | w_pop_ok);

    assign o_count     = w_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_afull     = (w_count >= c_afull_th);
    assign o_aempty    = (w_count <= c_aempty_th);
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

    // ------------------------------------------------------------------
    // Storage (not reset; stale entries are unreachable after reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && w_push_ok) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags; a new error event overrides a clear request
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~i_clr_err) | (i_push & ~w_push_ok);
            r_underflow <= (r_underflow & ~i_clr_err) | (i_pop  & ~w_pop_ok);
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is presented combinationally; forced to zero
            // while empty so nothing stale leaks out after reset.
            assign o_valid = ~w_empty;
            assign o_data  = w_empty ? '0 : r_mem[w_rd_idx];
        end else begin : g_reg_read
            logic [DATA_W-1:0] r_data;
            logic              r_valid;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_pop_ok;
                    if (w_pop_ok) begin
                        r_data <= r_mem[w_rd_idx];
                    end
                end
            end

            assign o_valid = r_valid;
            assign o_data  = r_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_param
//  Description : Self-checking bench for sync_fifo_param. One instance in
//                registered-read mode and one in first-word-fall-through mode
//                receive identical stimulus; a single queue model predicts
//                occupancy, flags and read data for both.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int c_data_w = 16;
    localparam int c_depth  = 8;
    localparam int c_aw     = 3;

    logic                clk;
    logic                rst_n;
    logic                i_push;
    logic [c_data_w-1:0] i_data;
    logic                i_pop;
    logic                i_clr_err;

    logic [c_data_w-1:0] o_data_reg,  o_data_fw;
    logic                o_valid_reg, o_valid_fw;
    logic                o_full_reg,  o_full_fw;
    logic                o_empty_reg, o_empty_fw;
    logic                o_afull_reg, o_afull_fw;
    logic                o_aempty_reg, o_aempty_fw;
    logic [c_aw:0]       o_count_reg, o_count_fw;
    logic                o_ovf_reg,   o_ovf_fw;
    logic                o_unf_reg,   o_unf_fw;

    sync_fifo_param #(
        .DATA_W(c_data_w), .DEPTH(c_depth), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(2)
    ) u_dut_reg (
        .clk(clk), .rst_n(rst_n), .i_push(i_push), .i_data(i_data), .i_pop(i_pop),
        .o_data(o_data_reg), .o_valid(o_valid_reg), .o_full(o_full_reg),
        .o_empty(o_empty_reg), .o_afull(o_afull_reg), .o_aempty(o_aempty_reg),
        .o_count(o_count_reg), .o_overflow(o_ovf_reg), .o_underflow(o_unf_reg),
        .i_clr_err(i_clr_err)
    );

    sync_fifo_param #(
        .DATA_W(c_data_w), .DEPTH(c_depth), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(2)
    ) u_dut_fw (
        .clk(clk), .rst_n(rst_n), .i_push(i_push), .i_data(i_data), .i_pop(i_pop),
        .o_data(o_data_fw), .o_valid(o_valid_fw), .o_full(o_full_fw),
        .o_empty(o_empty_fw), .o_afull(o_afull_fw), .o_aempty(o_aempty_fw),
        .o_count(o_count_fw), .o_overflow(o_ovf_fw), .o_underflow(o_unf_fw),
        .i_clr_err(i_clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [c_data_w-1:0] q[$];
    logic                m_ovf;
    logic                m_unf;
    logic [c_data_w-1:0] m_last;
    logic                m_valid_reg;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, advance the model with the
    // values the DUT saw at the rising edge, then compare 1 time unit later.
    task automatic step(input logic rst, input logic push, input logic [c_data_w-1:0] d,
                        input logic pop, input logic clr);
        int  sz;
        logic pop_ok;
        logic push_ok;
        @(negedge clk);
        rst_n     = ~rst;
        i_push    = push;
        i_data    = d;
        i_pop     = pop;
        i_clr_err = clr;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_ovf       = 1'b0;
            m_unf       = 1'b0;
            m_last      = '0;
            m_valid_reg = 1'b0;
        end else begin
            sz      = q.size();
            pop_ok  = pop && (sz > 0);
            push_ok = push && ((sz < c_depth) || pop_ok);
            if (pop_ok) m_last = q.pop_front();
            if (push_ok) q.push_back(d);
            m_ovf       = (m_ovf && !clr) || (push && !push_ok);
            m_unf       = (m_unf && !clr) || (pop && !pop_ok);
            m_valid_reg = pop_ok;
        end
        sz = q.size();
        check("count",     32'(o_count_reg),  32'(sz));
        check("full",      32'(o_full_reg),   32'(sz == c_depth));
        check("empty",     32'(o_empty_reg),  32'(sz == 0));
        check("afull",     32'(o_afull_reg),  32'(sz >= 6));
        check("aempty",    32'(o_aempty_reg), 32'(sz <= 2));
        check("overflow",  32'(o_ovf_reg),    32'(m_ovf));
        check("underflow", 32'(o_unf_reg),    32'(m_unf));
        check("valid_reg", 32'(o_valid_reg),  32'(m_valid_reg));
        check("data_reg",  32'(o_data_reg),   32'(m_last));
        check("count_fw",  32'(o_count_fw),   32'(sz));
        check("ovf_fw",    32'(o_ovf_fw),     32'(m_ovf));
        check("unf_fw",    32'(o_unf_fw),     32'(m_unf));
        check("valid_fw",  32'(o_valid_fw),   32'(sz != 0));
        if (sz != 0) check("data_fw", 32'(o_data_fw), 32'(q[0]));
        if (rst) check("data_fw_rst", 32'(o_data_fw), 32'h0);
    endtask

    task automatic drain();
        int n;
        n = q.size();
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    int msb_toggles;
    logic prev_msb;

    initial begin
        rst_n = 1'b0; i_push = 1'b0; i_data = '0; i_pop = 1'b0; i_clr_err = 1'b0;
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_last = '0; m_valid_reg = 1'b0;

        // Reset state
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Fill 1..8, then a dropped 9th push
        for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, 16'(k), 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0009, 1'b0, 1'b0);

        // Full: simultaneous push/pop keeps count at 8 with no new overflow
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'hAAAA, 1'b1, 1'b0);
        drain();
        check("last_word_aaaa", 32'(o_data_reg), 32'h0000AAAA);

        // Empty: simultaneous push/pop accepts only the push
        step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        // Clear coinciding with a new underflow: the set wins
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Fall-through of a single word, then its pop
        step(1'b0, 1'b1, 16'h00BE, 1'b0, 1'b0);
        check("fwft_first_word", 32'(o_data_fw), 32'h000000BE);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("fwft_valid_after_pop", 32'(o_valid_fw), 32'h0);

        // Wrap-around at constant occupancy 3
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 16'h0100 + 16'(k), 1'b0, 1'b0);
        msb_toggles = 0;
        prev_msb    = u_dut_reg.r_wr_ptr[c_aw];
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 16'h0200 + 16'(k), 1'b1, 1'b0);
            if (u_dut_reg.r_wr_ptr[c_aw] != prev_msb) msb_toggles++;
            prev_msb = u_dut_reg.r_wr_ptr[c_aw];
        end
        check("ptr_msb_toggled", 32'(msb_toggles >= 2), 32'h1);
        drain();

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            step(1'b0, 1'($urandom_range(0, 99) < 55), 16'($urandom),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 19) == 0));
        end
        drain();

        // Reset mid-operation at count 5, then behave as from power-up
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 16'h0C00 + 16'(k), 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h5A5A, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("post_reset_word", 32'(o_data_reg), 32'h00005A5A);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO; next generation of the team's basic datapath FIFO, used between the DTP producer and the output mux.
Adds configurable width and depth, a selectable read mode (registered or first-word-fall-through), occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
Push and pop in the same cycle are fully defined at every fill level, including full and empty.

Parameters:
DATA_W, 16, word width in bits (>=1)
DEPTH, 8, number of entries; power of 2, >=2
FWFT, 0, read mode: 0 = registered read (data one cycle after pop), 1 = first-word-fall-through
AFULL_TH, 6, o_afull asserted when count >= AFULL_TH; legal range 1..DEPTH
AEMPTY_TH, 2, o_aempty asserted when count <= AEMPTY_TH; legal range 0..DEPTH-1
AW, $clog2(DEPTH), derived localparam; not to be overridden

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
i_push  in  1  write request
i_data  in  DATA_W  write data
i_pop  in  1  read request
o_data  out  DATA_W  read data
o_valid  out  1  o_data valid qualifier
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_afull  out  1  count >= AFULL_TH
o_aempty  out  1  count <= AEMPTY_TH
o_count  out  AW+1  current occupancy, 0..DEPTH
o_overflow  out  1  sticky: push was dropped
o_underflow  out  1  sticky: pop was ignored
i_clr_err  in  1  clears both sticky error flags

Behaviour:
- Storage: DEPTH x DATA_W array.
- wr_ptr and rd_ptr are AW+1 bits each; the MSB is the wrap bit.
- count = wr_ptr - rd_ptr, modulo 2^(AW+1). Array index = pointer[AW-1:0].
- All status flags decode combinationally from the registered pointers. They are valid in the same cycle as the pointer update (visible after the clock edge, no extra latency).
- pop_ok = i_pop & !o_empty.
- push_ok = i_push & (!o_full | pop_ok). When full, a simultaneous push and pop is accepted: the head is read, the new word is written, and count stays DEPTH.
- When empty, a simultaneous push and pop accepts the push only. The pop is ignored and sets o_underflow; count becomes 1.
- push_ok: ram[wr_ptr] <= i_data, wr_ptr += 1.
- pop_ok: rd_ptr += 1.
- Pointers wrap naturally at 2^(AW+1). There is no special case for wrap-around.
- FWFT=0:
  - On pop_ok, o_data <= ram[rd_ptr] at that edge, and o_valid = 1 for exactly the following cycle.
  - With no pop_ok, o_valid = 0 and o_data holds its last value.
  - Read-to-data latency is 1 cycle.
- FWFT=1:
  - o_valid = !o_empty.
  - o_data = ram[rd_ptr] whenever o_valid = 1, with zero latency after the write edge.
  - The first word pushed into an empty FIFO appears on o_data in the cycle after the push.
  - pop_ok consumes the head; the next entry is presented in the following cycle.
- Errors:
  - o_overflow <= 1 when i_push & !push_ok.
  - o_underflow <= 1 when i_pop & !pop_ok.
  - i_clr_err clears both flags. If i_clr_err coincides with a new error event, set wins.
- Reset (rst_n=0 at a clk edge) applies regardless of any other input:
  - wr_ptr = rd_ptr = 0, o_count = 0, o_empty = 1, o_full = 0.
  - o_afull = 0, o_aempty = 1.
  - o_valid = 0, o_data = 0, o_overflow = o_underflow = 0.
- Reset mid-operation discards all stored data. Array contents are not cleared and are never observable after reset.
- push_ok and pop_ok are ignored during any cycle in which rst_n=0.

Test Plan:
- DEPTH=8, FWFT=0: push 0x0001..0x0008 -> o_full=1, o_count=8, o_afull=1 from count 6. A 9th push -> dropped, o_overflow=1, count stays 8. Pop x8 -> o_data 0x0001..0x0008 each one cycle after its pop with o_valid=1, then o_empty=1.
- Full FIFO, push 0xAAAA with pop in the same cycle -> o_count stays 8, no overflow. After draining, 0xAAAA is the last word out.
- Empty FIFO, push 0x1234 with pop in the same cycle -> o_count=1, o_underflow=1. Assert i_clr_err -> o_underflow=0.
- FWFT=1: push 0x00BE into an empty FIFO -> next cycle o_valid=1, o_data=0x00BE without a pop. Pop -> next cycle o_valid=0.
- Wrap-around: 20 interleaved push/pop pairs at count 3 -> data in order, o_count constant 3, pointer MSB toggles, flags correct throughout.
- Hold rst_n=0 for one cycle with count=5 -> next cycle o_count=0, o_empty=1, o_valid=0, error flags 0. A subsequent push/pop behaves as from power-up.
